ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- PC register and instruction-fetch sequencer for the rv64i core. Sits directly downstream of the next-PC selector and consumes its pcn output.
- Holds the architectural PC and issues one instruction-memory request per instruction over a valid/ready handshake.
- Captures the response and presents it to decode until the back end retires it. It then loads pcn (or a trap vector on misalignment) and fetches again.
- Strictly non-pipelined: one instruction in flight.

Parameters:
DATA_WIDTH, 64, PC and address width
INST_WIDTH, 32, instruction word width
RESET_PC, 64'h0000_0000_8000_0000, PC value after reset

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
pcn  input  DATA_WIDTH  next PC from next-PC selector, sampled on retire
retire  input  1  back end has completed current instruction (single-cycle pulse)
trap_vec  input  DATA_WIDTH  redirect target on misaligned pcn
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  DATA_WIDTH  fetch address (= pc)
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  INST_WIDTH  fetched instruction
imem_rsp_err  input  1  access fault on this response
pc  output  DATA_WIDTH  PC of instruction presented to decode
inst  output  INST_WIDTH  instruction presented to decode
inst_valid  output  1  inst/pc valid for decode
inst_fault  output  1  presented instruction had access fault
misalign  output  1  one-cycle pulse: retired pcn was misaligned
misalign_addr  output  DATA_WIDTH  offending pcn, held until next misalign
instret  output  64  retired-instruction counter

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=S_IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, inst_fault=0, imem_req_valid=0, misalign=0, misalign_addr=0, instret=0.
- All outputs are registered. imem_req_addr is driven from pc.
- FSM states:
  - S_IDLE: entered only via reset. Unconditionally moves to S_REQ on the first clk edge after rst_n deasserts, setting imem_req_valid=1.
  - S_REQ: imem_req_valid=1, addr=pc, both held stable until imem_req_valid&&imem_req_ready. On handshake: imem_req_valid<=0, go to S_WAIT.
  - S_WAIT: on imem_rsp_valid: inst<=imem_rsp_data, inst_fault<=imem_rsp_err, inst_valid<=1, go to S_HOLD.
    - On imem_rsp_err, inst<=NOP regardless of data.
    - The response is accepted no earlier than the cycle after the request handshake.
  - S_HOLD: outputs held. On retire: inst_valid<=0, inst_fault<=0, instret<=instret+1 (wraps mod 2^64), imem_req_valid<=1, go to S_REQ.
    - Next pc: if pcn[1:0]!=0 (IALIGN=32, no C extension), pc<=trap_vec, misalign<=1 for one cycle, misalign_addr<=pcn. Otherwise pc<=pcn.
- Latency: request issued the cycle after retire. inst_valid rises the cycle after imem_rsp_valid. Best-case retire-to-next-inst_valid = 3 cycles with a zero-wait memory (req accepted immediately, rsp the following cycle).
- Ignored inputs:
  - retire outside S_HOLD is ignored (no pc change, no count).
  - imem_rsp_valid outside S_WAIT is ignored.
  - pcn is only sampled in the retire cycle.
- Misaligned trap_vec is not checked; it is loaded as-is.
- rst_n assertion mid-request or mid-wait aborts immediately to reset values. Any later stray response is dropped because the FSM is not in S_WAIT.
- Retire and imem_rsp_valid in the same cycle: only the one legal for the current state acts.

Decomposition:
- Shared package (rv_pkg):
  - fetch state enum {S_IDLE, S_REQ, S_WAIT, S_HOLD}
  - NOP_INST = 32'h0000_0013
  - default RESET_PC
  - IALIGN_MASK = 2'b11
- No sub-module needed. The alignment check and counter are inline. The next-PC selector is instantiated by the parent, not inside this block.

Test Plan:
- Reset release with imem_req_ready=1, rsp 1 cycle later data=32'h00500093 -> req addr 0x80000000 on cycle 1; inst_valid=1, inst=0x00500093, pc=0x80000000 on cycle 3.
- Hold imem_req_ready=0 for 4 cycles -> imem_req_valid stays 1, addr constant, no state advance; handshake on cycle 5 proceeds normally.
- Retire with pcn=0x80000010 -> next request addr 0x80000010, instret increments 0->1; retire pulses sent while in S_REQ/S_WAIT do not change instret.
- Retire with pcn=0x80000006, trap_vec=0x80001000 -> misalign pulses 1 cycle, misalign_addr=0x80000006, next fetch addr 0x80001000.
- Response with imem_rsp_err=1, data=0xFFFFFFFF -> inst=0x00000013, inst_fault=1, inst_valid=1; cleared on retire.
- Assert rst_n low during S_WAIT, then send rsp_valid after release -> all outputs at reset values; stray response ignored; fetch restarts at 0x80000000.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the rv64i front end.
//   fetch_state_e    : instruction-fetch sequencer states
//   NOP_INST         : canonical NOP (addi x0,x0,0) shown to decode after reset or a fault
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   IALIGN_MASK      : PC low bits that must be zero (IALIGN=32, no C extension)
package rv_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [1:0]  IALIGN_MASK      = 2'b11;

endpackage

// File: rtl/ifu_fetch.sv
// PC register and non-pipelined instruction-fetch sequencer.
// Exactly one instruction is in flight at any time: request, wait for the
// response, present it to decode, and only after retire load the next PC.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pcn, retire, trap_vec : next PC, retire pulse, redirect target on misaligned pcn
//   imem_req_*            : fetch request (valid/ready), address is the PC
//   imem_rsp_*            : fetch response (valid, data, access-fault)
//   pc, inst, inst_valid, inst_fault : instruction presented to decode
//   misalign, misalign_addr          : misaligned-pcn pulse and offending address
//   instret               : retired-instruction counter
module ifu_fetch
   import rv_pkg::*;
#(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    INST_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC[DATA_WIDTH-1:0]
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] pcn,
   input  logic                  retire,
   input  logic [DATA_WIDTH-1:0] trap_vec,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   input  logic                  imem_rsp_err,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid,
   output logic                  inst_fault,
   output logic                  misalign,
   output logic [DATA_WIDTH-1:0] misalign_addr,
   output logic [63:0]           instret
);

   fetch_state_e state, state_nxt;

   // Each input only acts in the one state where it is legal; everything
   // else (stray retire, stray response) falls through untouched.
   logic req_fire, rsp_take, ret_take, pcn_mis;

   assign req_fire = (state == S_REQ)  && imem_req_ready;
   assign rsp_take = (state == S_WAIT) && imem_rsp_valid;
   assign ret_take = (state == S_HOLD) && retire;
   assign pcn_mis  = |(pcn[1:0] & IALIGN_MASK);

   assign imem_req_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ:   if (req_fire) state_nxt = S_WAIT;
         S_WAIT:  if (rsp_take) state_nxt = S_HOLD;
         S_HOLD:  if (ret_take) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         inst           <= NOP_INST[INST_WIDTH-1:0];
         inst_valid     <= 1'b0;
         inst_fault     <= 1'b0;
         imem_req_valid <= 1'b0;
         misalign       <= 1'b0;
         misalign_addr  <= '0;
         instret        <= '0;
      end else begin
         misalign <= 1'b0;  // single-cycle pulse

         if (state == S_IDLE) imem_req_valid <= 1'b1;
         if (req_fire)        imem_req_valid <= 1'b0;

         if (rsp_take) begin
            // A faulting response never exposes its data to decode.
            inst       <= imem_rsp_err ? NOP_INST[INST_WIDTH-1:0] : imem_rsp_data;
            inst_fault <= imem_rsp_err;
            inst_valid <= 1'b1;
         end

         if (ret_take) begin
            inst_valid     <= 1'b0;
            inst_fault     <= 1'b0;
            instret        <= instret + 64'd1;
            imem_req_valid <= 1'b1;
            if (pcn_mis) begin
               // trap_vec is trusted as-is; its alignment is not checked.
               pc            <= trap_vec;
               misalign      <= 1'b1;
               misalign_addr <= pcn;
            end else begin
               pc <= pcn;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed + randomized bench for ifu_fetch. The reference model tracks the
// architectural fetch contract only: which address is requested, what decode
// should see, how many instructions have retired and the last misaligned pcn.
module tb_ifu_fetch;
   import rv_pkg::*;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pcn, trap_vec;
   logic        retire;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid, imem_rsp_err;
   logic [31:0] imem_rsp_data;
   logic [63:0] pc;
   logic [31:0] inst;
   logic        inst_valid, inst_fault, misalign;
   logic [63:0] misalign_addr, instret;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [63:0] m_pc, m_mis_addr, m_instret;
   logic [31:0] m_inst;
   logic        m_fault;

   ifu_fetch dut (
      .clk(clk), .rst_n(rst_n), .pcn(pcn), .retire(retire), .trap_vec(trap_vec),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .pc(pc), .inst(inst), .inst_valid(inst_valid), .inst_fault(inst_fault),
      .misalign(misalign), .misalign_addr(misalign_addr), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc       = RPC;
      m_mis_addr = 64'd0;
      m_instret  = 64'd0;
      m_inst     = NOP_INST;
      m_fault    = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},        pc, RPC);
      chk({tag, "_inst"},      64'(inst), 64'(NOP_INST));
      chk({tag, "_ivalid"},    64'(inst_valid), 64'd0);
      chk({tag, "_ifault"},    64'(inst_fault), 64'd0);
      chk({tag, "_reqv"},      64'(imem_req_valid), 64'd0);
      chk({tag, "_misalign"},  64'(misalign), 64'd0);
      chk({tag, "_mis_addr"},  misalign_addr, 64'd0);
      chk({tag, "_instret"},   instret, 64'd0);
   endtask

   // Request phase: optional back-pressure cycles with stray retire/response
   // pulses that must have no effect, then a handshake.
   task automatic do_req(input int rdy_delay, input bit stray);
      chk("req_valid", 64'(imem_req_valid), 64'd1);
      chk("req_addr", imem_req_addr, m_pc);
      repeat (rdy_delay) begin
         imem_req_ready = 1'b0;
         if (stray) begin
            retire         = 1'($urandom_range(0, 1));
            pcn            = {$urandom, $urandom};
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
         end
         step();
         retire = 1'b0;
         imem_rsp_valid = 1'b0;
         chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
         chk("req_hold_addr", imem_req_addr, m_pc);
         chk("req_hold_ivalid", 64'(inst_valid), 64'd0);
         chk("req_hold_instret", instret, m_instret);
      end
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("req_drop", 64'(imem_req_valid), 64'd0);
   endtask

   // Response phase: wait dly cycles then deliver the response.
   task automatic do_rsp(input int dly, input logic [31:0] d, input bit err, input bit stray);
      repeat (dly) begin
         if (stray) retire = 1'($urandom_range(0, 1));
         step();
         retire = 1'b0;
         chk("wait_ivalid", 64'(inst_valid), 64'd0);
         chk("wait_instret", instret, m_instret);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      imem_rsp_err   = err;
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      m_inst  = err ? NOP_INST : d;
      m_fault = err;
      chk("rsp_ivalid", 64'(inst_valid), 64'd1);
      chk("rsp_inst", 64'(inst), 64'(m_inst));
      chk("rsp_fault", 64'(inst_fault), 64'(m_fault));
      chk("rsp_pc", pc, m_pc);
   endtask

   // Hold phase: stray responses must not disturb the presented instruction.
   task automatic do_hold(input int n);
      repeat (n) begin
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom_range(0, 1));
         step();
         imem_rsp_valid = 1'b0;
         imem_rsp_err   = 1'b0;
         chk("hold_ivalid", 64'(inst_valid), 64'd1);
         chk("hold_inst", 64'(inst), 64'(m_inst));
         chk("hold_fault", 64'(inst_fault), 64'(m_fault));
         chk("hold_reqv", 64'(imem_req_valid), 64'd0);
      end
   endtask

   task automatic do_retire(input logic [63:0] npc, input logic [63:0] tv);
      bit mis;
      pcn      = npc;
      trap_vec = tv;
      retire   = 1'b1;
      step();
      retire   = 1'b0;
      pcn      = {$urandom, $urandom};
      trap_vec = {$urandom, $urandom};
      mis = (npc[1:0] != 2'b00);
      m_instret = m_instret + 64'd1;
      if (mis) begin
         m_mis_addr = npc;
         m_pc       = tv;
      end else begin
         m_pc = npc;
      end
      chk("ret_instret", instret, m_instret);
      chk("ret_ivalid", 64'(inst_valid), 64'd0);
      chk("ret_fault", 64'(inst_fault), 64'd0);
      chk("ret_misalign", 64'(misalign), 64'(mis));
      chk("ret_mis_addr", misalign_addr, m_mis_addr);
      chk("ret_reqv", 64'(imem_req_valid), 64'd1);
      chk("ret_addr", imem_req_addr, m_pc);
      step();
      chk("ret_misalign_end", 64'(misalign), 64'd0);
      chk("ret_mis_addr_keep", misalign_addr, m_mis_addr);
   endtask

   initial begin
      rst_n = 1'b0;
      pcn = '0; trap_vec = '0; retire = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; imem_rsp_err = 1'b0;
      model_reset();

      // Reset state, then release: first request on cycle 1, inst on cycle 3.
      step(); step();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      step();
      do_req(0, 1'b0);
      do_rsp(0, 32'h0050_0093, 1'b0, 1'b0);
      do_hold(2);
      do_retire(64'h8000_0010, 64'h8000_1000);

      // Back-pressure and stray retires in S_REQ/S_WAIT.
      do_req(4, 1'b1);
      do_rsp(2, 32'h0010_0113, 1'b0, 1'b1);
      do_hold(1);
      do_retire(64'h8000_0006, 64'h8000_1000);

      // Access fault hides data, cleared on retire.
      do_req(0, 1'b0);
      do_rsp(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_hold(1);
      do_retire(64'h8000_1004, 64'h8000_2000);

      // Reset during S_WAIT, stray response after release is dropped.
      do_req(0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_reset_vals("midrst");
      step();
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      step();
      imem_rsp_valid = 1'b0;
      chk("midrst_ivalid", 64'(inst_valid), 64'd0);
      chk("midrst_inst", 64'(inst), 64'(NOP_INST));
      chk("midrst_instret", instret, 64'd0);

      // Randomized transactions.
      for (int i = 0; i < 40; i++) begin
         logic [63:0] npc, tv;
         do_req($urandom_range(0, 3), 1'b1);
         do_rsp($urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0), 1'b1);
         do_hold($urandom_range(0, 2));
         npc = (m_pc + 64'(4 * $urandom_range(0, 8))) & ~64'd3;
         if ($urandom_range(0, 2) == 0) npc[1:0] = 2'($urandom_range(1, 3));
         tv = {32'd0, $urandom};
         do_retire(npc, tv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
